// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, long-latency write, reservations and hazard lookups.
// master = pipeline/long-latency side, slave = the write arbiter.
interface regfile_wr_arbiter_if;
  logic        p_we;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;

  logic        m_valid;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_ready;

  logic        rsv_valid;
  logic [4:0]  rsv_addr;

  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        hazard1;
  logic        hazard2;

  logic        stall_req;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output p_we, p_waddr, p_wdata,
    output m_valid, m_waddr, m_wdata,
    input  m_ready,
    output rsv_valid, rsv_addr,
    output rd_addr1, rd_addr2,
    input  hazard1, hazard2,
    input  stall_req,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  p_we, p_waddr, p_wdata,
    input  m_valid, m_waddr, m_wdata,
    output m_ready,
    input  rsv_valid, rsv_addr,
    input  rd_addr1, rd_addr2,
    output hazard1, hazard2,
    output stall_req,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates one register-file write port between the pipeline and a one-entry long-latency buffer.
// Pipeline wins by default; after STARVE_MAX blocked cycles the buffer drains and stall_req holds the pipeline.
module regfile_wr_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  buf_state_e  state_q, state_d;
  wr_t         buf_q, buf_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic [31:1] busy_q, busy_d;

  logic        buf_valid;
  logic        active;
  logic        stall;
  logic        drain;
  logic        load;
  logic        m_rdy;
  logic [31:0] busy_vec;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  assign buf_valid = (state_q == BUF_FULL);
  assign active    = bus.p_we && (bus.p_waddr != 5'd0);
  assign stall     = buf_valid && (starve_cnt_q == STARVE_LIM);
  assign drain     = buf_valid && (!active || stall);
  // Gate with rst so the handshake reads low while the block is held in reset.
  assign m_rdy     = rst && !buf_valid;
  // Writes to r0 are accepted to keep the unit flowing but never occupy the buffer.
  assign load      = bus.m_valid && m_rdy && (bus.m_waddr != 5'd0);
  assign busy_vec  = {busy_q, 1'b0};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BUF_EMPTY;
      buf_q        <= '0;
      starve_cnt_q <= '0;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      BUF_EMPTY: begin
        if (load) begin
          state_d   = BUF_FULL;
          buf_d     = '{addr: bus.m_waddr, data: bus.m_wdata};
        end
      end
      BUF_FULL: begin
        if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_comb begin
    starve_cnt_d = 3'd0;
    if (buf_valid && active && !stall) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  // A reservation issued on the drain edge of the same register must survive.
  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (drain) begin
      clr_vec = 32'd1 << buf_q.addr;
    end
    if (bus.rsv_valid && (bus.rsv_addr != 5'd0)) begin
      set_vec = 32'd1 << bus.rsv_addr;
    end
    busy_d = (busy_q & ~clr_vec[31:1]) | set_vec[31:1];
  end

  // Output logic
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (rst) begin
      if (drain) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = buf_q.addr;
        bus.rf_wdata = buf_q.data;
      end else if (active) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.p_waddr;
        bus.rf_wdata = bus.p_wdata;
      end
    end
  end

  assign bus.m_ready   = m_rdy;
  assign bus.stall_req = stall;
  assign bus.hazard1   = busy_vec[bus.rd_addr1];
  assign bus.hazard2   = busy_vec[bus.rd_addr2];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed corner sequences plus random traffic,
// scored against a queue-based model of the pending write, starvation count and reservations.
module tb_regfile_wr_arbiter;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if bus();

  regfile_wr_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        rv;
    logic [4:0]  ra;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } stim_t;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        stall;
    logic        mrdy;
    logic        h1;
    logic        h2;
  } exp_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  stim_t     st;
  exp_t      exp_q[$];
  exp_t      mon_e;
  wr_t       pend[$];
  bit [31:0] busy_m;
  int        blocked;
  int        n_checks = 0;
  int        n_err = 0;

  logic        s_rf_we, s_stall, s_mrdy, s_h1, s_h2;
  logic [4:0]  s_rf_waddr;
  logic [31:0] s_rf_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic clr_st();
    st = '{default: '0};
  endtask

  task automatic drive_st();
    bus.p_we      = st.pwe;
    bus.p_waddr   = st.pa;
    bus.p_wdata   = st.pd;
    bus.m_valid   = st.mv;
    bus.m_waddr   = st.ma;
    bus.m_wdata   = st.md;
    bus.rsv_valid = st.rv;
    bus.rsv_addr  = st.ra;
    bus.rd_addr1  = st.r1;
    bus.rd_addr2  = st.r2;
  endtask

  task automatic model_reset();
    pend.delete();
    busy_m  = '0;
    blocked = 0;
  endtask

  // One clock cycle: apply st, predict the outputs, sample at negedge, advance the model at posedge.
  task automatic step();
    exp_t e;
    logic active, full, take_buf;
    drive_st();
    active   = st.pwe && (st.pa != 5'd0);
    full     = (pend.size() != 0);
    e.stall  = full && (blocked == STARVE);
    e.mrdy   = !full;
    e.h1     = busy_m[st.r1];
    e.h2     = busy_m[st.r2];
    take_buf = full && (!active || e.stall);
    e.we = 1'b0;
    e.a  = 5'd0;
    e.d  = 32'd0;
    if (take_buf) begin
      e.we = 1'b1;
      e.a  = pend[0].a;
      e.d  = pend[0].d;
    end else if (active) begin
      e.we = 1'b1;
      e.a  = st.pa;
      e.d  = st.pd;
    end
    exp_q.push_back(e);
    @(negedge clk);
    s_rf_we    = bus.rf_we;
    s_rf_waddr = bus.rf_waddr;
    s_rf_wdata = bus.rf_wdata;
    s_stall    = bus.stall_req;
    s_mrdy     = bus.m_ready;
    s_h1       = bus.hazard1;
    s_h2       = bus.hazard2;
    @(posedge clk);
    if (take_buf) begin
      busy_m[pend[0].a] = 1'b0;
      void'(pend.pop_front());
      blocked = 0;
    end else if (full && active) begin
      blocked++;
    end
    if (st.mv && !full && st.ma != 5'd0) pend.push_back('{st.ma, st.md});
    if (st.rv && st.ra != 5'd0) busy_m[st.ra] = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("sb_rf_we", 32'(bus.rf_we), 32'(mon_e.we));
      if (mon_e.we) begin
        check("sb_rf_waddr", 32'(bus.rf_waddr), 32'(mon_e.a));
        check("sb_rf_wdata", bus.rf_wdata, mon_e.d);
      end
      check("sb_stall_req", 32'(bus.stall_req), 32'(mon_e.stall));
      check("sb_m_ready", 32'(bus.m_ready), 32'(mon_e.mrdy));
      check("sb_hazard1", 32'(bus.hazard1), 32'(mon_e.h1));
      check("sb_hazard2", 32'(bus.hazard2), 32'(mon_e.h2));
    end
  end

  initial begin
    rst = 1'b0;
    clr_st();
    drive_st();
    model_reset();
    s_stall = 1'b0;
    #2;
    check("rst_m_ready", 32'(bus.m_ready), 0);
    check("rst_rf_we", 32'(bus.rf_we), 0);
    check("rst_stall", 32'(bus.stall_req), 0);
    check("rst_hazard1", 32'(bus.hazard1), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Idle pipeline, long-latency write to r5
    st.mv = 1'b1; st.ma = 5'd5; st.md = 32'hA5A5A5A5;
    step();
    check("first_m_ready", 32'(s_mrdy), 1);
    clr_st();
    step();
    check("lat_rf_we", 32'(s_rf_we), 1);
    check("lat_rf_waddr", 32'(s_rf_waddr), 5);
    check("lat_rf_wdata", s_rf_wdata, 32'hA5A5A5A5);
    check("lat_m_ready_busy", 32'(s_mrdy), 0);
    step();
    check("lat_m_ready_back", 32'(s_mrdy), 1);
    check("lat_rf_we_idle", 32'(s_rf_we), 0);

    // Starvation: pipeline held on r3 while the buffer waits
    for (int rep = 0; rep < 2; rep++) begin
      clr_st();
      st.pwe = 1'b1; st.pa = 5'd3; st.pd = 32'h33330000 + rep;
      st.mv = 1'b1; st.ma = 5'(10 + rep); st.md = 32'hBEEF0000 + rep;
      step();
      check("starve_load_pipe", 32'(s_rf_waddr), 3);
      st.mv = 1'b0;
      for (int k = 0; k < STARVE; k++) begin
        step();
        check("starve_pipe_wins", 32'(s_rf_waddr), 3);
        check("starve_no_stall", 32'(s_stall), 0);
      end
      step();
      check("starve_stall", 32'(s_stall), 1);
      check("starve_buf_addr", 32'(s_rf_waddr), 32'(10 + rep));
      check("starve_buf_data", s_rf_wdata, 32'hBEEF0000 + rep);
      step();
      check("starve_after_stall", 32'(s_stall), 0);
      check("starve_after_pipe", 32'(s_rf_waddr), 3);
    end

    // Reservation of r7 cleared only by its buffered write
    clr_st();
    step();
    st.rv = 1'b1; st.ra = 5'd7; st.r1 = 5'd7;
    step();
    check("rsv_no_bypass", 32'(s_h1), 0);
    st.rv = 1'b0;
    step();
    check("rsv_hazard_set", 32'(s_h1), 1);
    st.mv = 1'b1; st.ma = 5'd7; st.md = 32'h00007777;
    step();
    check("rsv_hazard_load", 32'(s_h1), 1);
    st.mv = 1'b0;
    step();
    check("rsv_drain_addr", 32'(s_rf_waddr), 7);
    check("rsv_hazard_drain", 32'(s_h1), 1);
    step();
    check("rsv_hazard_clear", 32'(s_h1), 0);

    // Set and clear on r9 in the same cycle
    clr_st();
    st.rv = 1'b1; st.ra = 5'd9; st.r1 = 5'd9;
    step();
    st.rv = 1'b0; st.mv = 1'b1; st.ma = 5'd9; st.md = 32'h99;
    step();
    st.mv = 1'b0; st.rv = 1'b1;
    step();
    check("setclr_drain_addr", 32'(s_rf_waddr), 9);
    st.rv = 1'b0;
    step();
    check("setclr_busy_kept", 32'(s_h1), 1);
    st.mv = 1'b1;
    step();
    st.mv = 1'b0;
    step();
    step();
    check("setclr_busy_gone", 32'(s_h1), 0);

    // Writes and reservations targeting r0
    clr_st();
    st.mv = 1'b1; st.ma = 5'd0; st.md = 32'hDEADBEEF;
    step();
    check("r0_m_ready", 32'(s_mrdy), 1);
    st.mv = 1'b0;
    step();
    check("r0_no_write", 32'(s_rf_we), 0);
    check("r0_buf_empty", 32'(s_mrdy), 1);
    st.rv = 1'b1; st.ra = 5'd0;
    step();
    st.rv = 1'b0;
    step();
    check("r0_hazard1", 32'(s_h1), 0);
    check("r0_hazard2", 32'(s_h2), 0);

    // Asynchronous reset with buffer full and a reservation outstanding
    clr_st();
    st.rv = 1'b1; st.ra = 5'd12;
    step();
    st.rv = 1'b0; st.pwe = 1'b1; st.pa = 5'd3; st.pd = 32'h3;
    st.mv = 1'b1; st.ma = 5'd12; st.md = 32'hC0C0;
    step();
    st.mv = 1'b0; st.r1 = 5'd12;
    step();
    check("pre_rst_hazard", 32'(s_h1), 1);
    check("pre_rst_full", 32'(s_mrdy), 0);
    rst = 1'b0;
    #1;
    check("arst_rf_we", 32'(bus.rf_we), 0);
    check("arst_m_ready", 32'(bus.m_ready), 0);
    check("arst_stall", 32'(bus.stall_req), 0);
    check("arst_hazard1", 32'(bus.hazard1), 0);
    check("arst_hazard2", 32'(bus.hazard2), 0);
    model_reset();
    clr_st();
    drive_st();
    @(posedge clk);
    #1 rst = 1'b1;
    st.r1 = 5'd12;
    step();
    check("post_rst_m_ready", 32'(s_mrdy), 1);
    check("post_rst_hazard", 32'(s_h1), 0);
    check("post_rst_no_write", 32'(s_rf_we), 0);

    // Random traffic; a stalled pipeline re-presents its write
    s_stall = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!s_stall) begin
        st.pwe = ($urandom_range(0, 9) < 7);
        st.pa  = 5'($urandom_range(0, 15));
        st.pd  = $urandom;
      end
      st.mv = 1'($urandom_range(0, 1));
      st.ma = 5'($urandom_range(0, 15));
      st.md = $urandom;
      st.rv = ($urandom_range(0, 3) == 0);
      st.ra = 5'($urandom_range(0, 15));
      st.r1 = 5'($urandom_range(0, 15));
      st.r2 = 5'($urandom_range(0, 15));
      step();
    end

    clr_st();
    repeat (2) step();
    if (exp_q.size() != 0) check("sb_queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
